program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/simple_cpu_pkg.sv | 6 +
 rtl/loader_csum.sv | 13 +
 rtl/program_loader.sv | 98 +++++++++
 tb/tb_program_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: shared widths and program loader state encoding.
package simple_cpu_pkg;
  localparam int INST_W = 23;
  localparam int ADDR_W = 6;
  typedef enum logic [2:0] {IDLE, B0, B1, B2, WR, CHK, DONE} ld_state_t;
endpackage

// File: rtl/loader_csum.sv
// loader_csum: running XOR of the program byte stream.
module loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] byte_in,
  output logic [7:0] sum
);
  always_ff @(posedge clk)
    if (reset || clear) sum <= '0;
    else if (enable) sum <= sum ^ byte_in;
endmodule

// File: rtl/program_loader.sv
// program_loader: assembles 3-byte instructions from a byte stream and writes them to program memory.
// Optional trailing checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int INST_W = simple_cpu_pkg::INST_W,
  parameter int ADDR_W = simple_cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [INST_W-1:0] program_out,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic              start,
  output logic              busy,
  output logic              err
);
  import simple_cpu_pkg::*;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(2**ADDR_W);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam ld_state_t LAST_ST = CHK;
`else
  localparam ld_state_t LAST_ST = DONE;
`endif
  ld_state_t r_state, w_next;
  logic [ADDR_W:0] r_len, w_len;
  logic [ADDR_W-1:0] r_idx;
  logic [INST_W-9:0] r_word;
  logic w_xfer, w_last, w_start_load, w_unused;
  assign w_unused = &{1'b0, s_data};
  assign w_len = prog_len > MAX_LEN ? MAX_LEN : prog_len;
  assign w_start_load = r_state == IDLE && load_req;
  assign w_xfer = s_valid && s_ready;
  assign w_last = {1'b0, r_idx} == r_len - (ADDR_W+1)'(1);
  // Gated by reset so a byte offered during the reset cycle is never taken.
  assign s_ready = !reset && (r_state == B0 || r_state == B1 || r_state == B2 || r_state == CHK);
  assign write = !reset && r_state == WR;
  assign start = !reset && r_state == DONE;
  assign busy = r_state != IDLE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] w_sum;
  logic r_err;
  loader_csum u_csum (
    .clk(clk),
    .reset(reset),
    .clear(w_start_load),
    .enable(w_xfer && r_state != CHK),
    .byte_in(s_data),
    .sum(w_sum)
  );
  assign err = r_err;
  always_ff @(posedge clk)
    if (reset) r_err <= 1'b0;
    else if (w_start_load) r_err <= 1'b0;
    else if (r_state == CHK && w_xfer && s_data != w_sum) r_err <= 1'b1;
`else
  assign err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = load_req && w_len != '0 ? B0 : IDLE;
      B0:   w_next = w_xfer ? B1 : B0;
      B1:   w_next = w_xfer ? B2 : B1;
      B2:   w_next = w_xfer ? WR : B2;
      WR:   w_next = w_last ? LAST_ST : B0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK:  w_next = !w_xfer ? CHK : s_data == w_sum ? DONE : IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_len <= '0;
      r_idx <= '0;
      r_word <= '0;
      program_out <= '0;
      address <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_load) begin
        r_len <= w_len;
        r_idx <= '0;
      end
      if (r_state == WR && !w_last) r_idx <= r_idx + ADDR_W'(1);
      if (w_xfer && r_state == B0) r_word[INST_W-9:8] <= s_data[INST_W-17:0];
      if (w_xfer && r_state == B1) r_word[7:0] <= s_data;
      if (w_xfer && r_state == B2) begin
        program_out <= {r_word, s_data};
        address <= r_idx;
      end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of the program loader (checksum cases when PROGRAM_LOADER_CHECKSUM_EN is defined).
module tb_program_loader;
  localparam int IW = 23;
  localparam int AW = 6;
  logic clk = 0, reset = 1, load_req = 0, s_valid = 0;
  logic [AW:0] prog_len = '0;
  logic [7:0] s_data = '0;
  logic s_ready, write, start, busy, err;
  logic [IW-1:0] program_out;
  logic [AW-1:0] address;
  int n_chk = 0, n_bad = 0, cyc = 0, n_start = 0, wr_cyc = 0, st_cyc = 0;
  logic [AW-1:0] aq[$];
  logic [IW-1:0] dq[$];
  program_loader dut (
    .clk(clk), .reset(reset), .load_req(load_req), .prog_len(prog_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .program_out(program_out), .write(write), .address(address),
    .start(start), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (write) begin
      aq.push_back(address);
      dq.push_back(program_out);
      wr_cyc = cyc;
    end
    if (start) begin
      n_start++;
      st_cyc = cyc;
    end
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clr;
    aq.delete();
    dq.delete();
    n_start = 0;
  endtask
  task automatic go(logic [AW:0] len);
    prog_len = len;
    load_req = 1;
    step();
    load_req = 0;
  endtask
  task automatic send(logic [7:0] b);
    int t = 0;
    s_data = b;
    s_valid = 1;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) chk("ready_tmo", 32'(s_ready), 1);
    step();
  endtask
  task automatic send_word(logic [IW-1:0] w, logic b7);
    send({b7, w[22:16]});
    send(w[15:8]);
    send(w[7:0]);
  endtask
  function automatic logic [IW-1:0] wd(int i);
    logic [7:0] b = 8'(i);
    return {b[6:0], b ^ 8'h5A, ~b};
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    step(2);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_pout", 32'(program_out), 0);
    chk("rst_addr", 32'(address), 0);
    reset = 0;
    step();
    chk("idle_busy", 32'(busy), 0);
    // single word
    clr();
    go(1);
    send(8'h81);
    send(8'h23);
    send(8'h45);
    s_valid = 0;
    chk("w1_write", 32'(write), 1);
    chk("w1_addr", 32'(address), 0);
    chk("w1_pout", 32'(program_out), 32'h012345);
    step(3);
    chk("w1_nwr", aq.size(), 1);
    chk("w1_nstart", n_start, 1);
    chk("w1_lat", st_cyc - wr_cyc, 1);
    chk("w1_busy", 32'(busy), 0);
    chk("w1_hold", 32'(program_out), 32'h012345);
    // stall between B1 and B2
    clr();
    go(1);
    send(8'hAA);
    send(8'hBB);
    s_valid = 0;
    step(5);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_nwr", aq.size(), 0);
    chk("stall_ready", 32'(s_ready), 1);
    send(8'hCC);
    s_valid = 0;
    step(3);
    chk("stall_nwr2", aq.size(), 1);
    chk("stall_word", 32'(dq[0]), 32'h2ABBCC);
    chk("stall_start", n_start, 1);
    // full 64-word load
    clr();
    go(64);
    for (int i = 0; i < 64; i++) send_word(wd(i), 1'(i));
    s_valid = 0;
    step(3);
    chk("full_nwr", aq.size(), 64);
    chk("full_start", n_start, 1);
    chk("full_busy", 32'(busy), 0);
    for (int i = 0; i < 64 && i < aq.size(); i++) begin
      chk($sformatf("full_addr%0d", i), 32'(aq[i]), i);
      chk($sformatf("full_word%0d", i), 32'(dq[i]), 32'(wd(i)));
    end
    // length above capacity clamps to 64
    clr();
    go(100);
    for (int i = 0; i < 64; i++) send_word(wd(i + 7), 0);
    s_valid = 0;
    step(3);
    chk("clamp_nwr", aq.size(), 64);
    chk("clamp_start", n_start, 1);
    chk("clamp_busy", 32'(busy), 0);
    chk("clamp_last", 32'(address), 63);
    // load_req while busy is ignored
    clr();
    go(1);
    send(8'h01);
    s_valid = 0;
    go(5);
    send(8'h02);
    send(8'h03);
    s_valid = 0;
    step(3);
    chk("ign_nwr", aq.size(), 1);
    chk("ign_word", 32'(dq[0]), 32'h010203);
    chk("ign_start", n_start, 1);
    chk("ign_busy", 32'(busy), 0);
    // zero length stays idle
    clr();
    go(0);
    chk("zero_busy", 32'(busy), 0);
    step(3);
    chk("zero_nwr", aq.size(), 0);
    chk("zero_start", n_start, 0);
    // reset in B1 of word 3
    clr();
    go(5);
    for (int i = 0; i < 3; i++) send_word(wd(i + 20), 0);
    send(8'h11);
    s_data = 8'h22;
    reset = 1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(s_ready), 0);
    step();
    chk("mid_pout", 32'(program_out), 0);
    chk("mid_addr", 32'(address), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_write", 32'(write), 0);
    chk("mid_start", 32'(start), 0);
    reset = 0;
    step();
    chk("mid_ready", 32'(s_ready), 0);
    s_valid = 0;
    step(5);
    chk("mid_nwr", aq.size(), 3);
    chk("mid_nstart", n_start, 0);
    clr();
    go(1);
    send_word(wd(9), 1);
    s_valid = 0;
    step(3);
    chk("re_nwr", aq.size(), 1);
    chk("re_addr", 32'(aq[0]), 0);
    chk("re_word", 32'(dq[0]), 32'(wd(9)));
    chk("re_start", n_start, 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    clr();
    go(1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h00);
    s_valid = 0;
    step(3);
    chk("cs_ok_start", n_start, 1);
    chk("cs_ok_err", 32'(err), 0);
    chk("cs_ok_nwr", aq.size(), 1);
    clr();
    go(1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h55);
    s_valid = 0;
    step(3);
    chk("cs_bad_start", n_start, 0);
    chk("cs_bad_err", 32'(err), 1);
    chk("cs_bad_busy", 32'(busy), 0);
`endif
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
